// File: rtl/noc_pkg.sv
// Shared NoC definitions: widths, flit-type encodings, injector FSM states, descriptor payload.
package noc_pkg;

  localparam int unsigned MAXVC   = 4;
  localparam int unsigned DST_W   = 6;
  localparam int unsigned NFLIT_W = 8;
  localparam int unsigned CYC_W   = 16;
  localparam int unsigned VC_W    = $clog2(MAXVC);

  localparam logic [1:0] FLIT_BODY     = 2'b00;
  localparam logic [1:0] FLIT_HEAD     = 2'b01;
  localparam logic [1:0] FLIT_TAIL     = 2'b10;
  localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_t;

  typedef struct packed {
    logic [DST_W-1:0]   dst;
    logic [VC_W-1:0]    vc;
    logic [NFLIT_W-1:0] num_flit;
  } desc_t;

  // Tail bit on the last flit, head bit on flit 0; a one-flit packet gets both.
  function automatic logic [1:0] flit_type_of(input logic [NFLIT_W-1:0] seq,
                                              input logic [NFLIT_W-1:0] num);
    return {seq == (num - NFLIT_W'(1)), seq == '0};
  endfunction

endpackage

// File: rtl/flit_injector_if.sv
// Fill-side descriptor handshake plus router injection slot of the flit injector.
interface flit_injector_if;
  import noc_pkg::*;

  logic               fill_valid;
  logic               fill_ready;
  logic [DST_W-1:0]   fill_dst;
  logic [VC_W-1:0]    fill_vc;
  logic [NFLIT_W-1:0] fill_num_flit;
  logic [MAXVC-1:0]   can_inject;
  logic [CYC_W-1:0]   in_cycle;
  logic               flit_valid;
  logic               flit_accept;
  logic [1:0]         flit_type;
  logic [DST_W-1:0]   flit_dst;
  logic [VC_W-1:0]    flit_vc;
  logic [NFLIT_W-1:0] flit_seq;
  logic [CYC_W-1:0]   flit_time;
  logic               done;
  logic               err_zero_len;

  modport slave (
    input  fill_valid, fill_dst, fill_vc, fill_num_flit, can_inject, in_cycle, flit_accept,
    output fill_ready, flit_valid, flit_type, flit_dst, flit_vc, flit_seq, flit_time,
           done, err_zero_len
  );

  modport master (
    output fill_valid, fill_dst, fill_vc, fill_num_flit, can_inject, in_cycle, flit_accept,
    input  fill_ready, flit_valid, flit_type, flit_dst, flit_vc, flit_seq, flit_time,
           done, err_zero_len
  );

endinterface

// File: rtl/inj_desc_fifo.sv
// Synchronous descriptor FIFO; pointers carry one wrap bit so full/empty come from an MSB compare.
module inj_desc_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  desc_t i_din,
  input  logic  i_pop,
  output desc_t o_dout,
  output logic  o_full,
  output logic  o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  desc_t       r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_dout  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push && !o_full) r_wr <= r_wr + (AW+1)'(1);
      if (i_pop && !o_empty) r_rd <= r_rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/flit_injector.sv
// Source injection stage: queues packet descriptors and segments them into flits for router port 0.
// Optional FLIT_INJ_TIMESTAMP_EN stamps every flit with the cycle its head was first presented.
module flit_injector
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  flit_injector_if.slave bus
);

  inj_state_t         r_state;
  desc_t              r_cur;
  logic [NFLIT_W-1:0] r_seq;
  logic [NFLIT_W-1:0] r_rem;
  logic               r_err;

  desc_t w_din;
  desc_t w_head;
  logic  w_full;
  logic  w_empty;
  logic  w_take;
  logic  w_push;
  logic  w_pop;
  logic  w_valid;
  logic  w_fire;
  logic  w_last;

  assign w_din  = '{dst: bus.fill_dst, vc: bus.fill_vc, num_flit: bus.fill_num_flit};
  assign w_take = bus.fill_valid && !w_full;
  assign w_push = w_take && (bus.fill_num_flit != '0);

  assign w_valid = (r_state == ST_SEND) && bus.can_inject[r_cur.vc];
  assign w_fire  = w_valid && bus.flit_accept;
  assign w_last  = (r_rem == NFLIT_W'(1));
  // Next descriptor loads from IDLE or straight after an accepted tail, giving zero-bubble packets.
  assign w_pop   = !w_empty && ((r_state == ST_IDLE) || (w_fire && w_last));

  inj_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_seq   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_take && (bus.fill_num_flit == '0)) r_err <= 1'b1;
      if (w_fire) begin
        r_seq <= r_seq + NFLIT_W'(1);
        r_rem <= r_rem - NFLIT_W'(1);
        if (w_last) r_state <= ST_IDLE;
      end
      if (w_pop) begin
        r_cur   <= w_head;
        r_seq   <= '0;
        r_rem   <= w_head.num_flit;
        r_state <= ST_SEND;
      end
    end
  end

  assign bus.fill_ready   = !w_full;
  assign bus.flit_valid   = w_valid;
  assign bus.flit_type    = (r_state == ST_SEND) ? flit_type_of(r_seq, r_cur.num_flit) : FLIT_BODY;
  assign bus.flit_dst     = r_cur.dst;
  assign bus.flit_vc      = r_cur.vc;
  assign bus.flit_seq     = r_seq;
  assign bus.done         = (r_state == ST_IDLE) && w_empty;
  assign bus.err_zero_len = r_err;

`ifdef FLIT_INJ_TIMESTAMP_EN
  logic             r_stamped;
  logic [CYC_W-1:0] r_time;

  // Until the head has been presented, the live cycle is shown so the head carries its own stamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stamped <= 1'b0;
      r_time    <= '0;
    end else if (w_pop) begin
      r_stamped <= 1'b0;
    end else if (w_valid && (r_seq == '0) && !r_stamped) begin
      r_stamped <= 1'b1;
      r_time    <= bus.in_cycle;
    end
  end

  assign bus.flit_time = ((r_state == ST_SEND) && !r_stamped) ? bus.in_cycle : r_time;
`else
  assign bus.flit_time = '0;
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: directed scenarios plus a randomized run against a flit-queue model.
module tb_flit_injector;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cyc = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  flit_injector_if bus ();

  flit_injector #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign bus.in_cycle = cyc;

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.fill_valid    = 1'b0;
    bus.fill_dst      = '0;
    bus.fill_vc       = '0;
    bus.fill_num_flit = '0;
    bus.can_inject    = 4'b1111;
    bus.flit_accept   = 1'b1;
  endtask

  task automatic offer(input int dst, input int vc, input int n);
    bus.fill_valid    = 1'b1;
    bus.fill_dst      = DST_W'(dst);
    bus.fill_vc       = VC_W'(vc);
    bus.fill_num_flit = NFLIT_W'(n);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    start_cycle();
    start_cycle();
    rst = 1'b0;
  endtask

  // Expected type from the packet's shape.
  function automatic logic [1:0] exp_type(input int seq, input int n);
    if (n == 1)          return 2'b11;
    else if (seq == 0)   return 2'b01;
    else if (seq == n-1) return 2'b10;
    else                 return 2'b00;
  endfunction

  function automatic logic [17:0] flit_vec(input int dst, input int vc, input int seq, input int n);
    return {DST_W'(dst), VC_W'(vc), NFLIT_W'(seq), exp_type(seq, n)};
  endfunction

  function automatic logic [17:0] got_vec();
    return {bus.flit_dst, bus.flit_vc, bus.flit_seq, bus.flit_type};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    n_cmp++; if (bus.flit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.flit_valid); end
    n_cmp++; if (got_vec() !== 18'h0) begin n_bad++; $display("FAIL reset_fields got=%h exp=0", got_vec()); end
    n_cmp++; if (bus.flit_time !== 16'h0) begin n_bad++; $display("FAIL reset_time got=%h exp=0", bus.flit_time); end
    n_cmp++; if ({bus.done, bus.err_zero_len, bus.fill_ready} !== 3'b101)
      begin n_bad++; $display("FAIL reset_status got=%b exp=101", {bus.done, bus.err_zero_len, bus.fill_ready}); end
    start_cycle();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic exp_v;
    do_reset();
    offer(3, 1, 3);
    for (int c = 1; c <= 5; c++) begin
      start_cycle();
      bus.fill_valid = 1'b0;
      @(negedge clk);
      exp_v = (c >= 2) && (c <= 4);
      n_cmp++; if (bus.flit_valid !== exp_v) begin n_bad++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, bus.flit_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (got_vec() !== flit_vec(3, 1, c-2, 3))
          begin n_bad++; $display("FAIL basic_flit c=%0d got=%h exp=%h", c, got_vec(), flit_vec(3, 1, c-2, 3)); end
      end
      n_cmp++; if (bus.done !== (c == 5)) begin n_bad++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, bus.done, (c == 5)); end
    end
  endtask

  task automatic test_single_zero();
    logic exp_v;
    do_reset();
    offer(5, 0, 1);
    start_cycle();
    offer(2, 3, 0);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) start_cycle();
      if (c > 1) bus.fill_valid = 1'b0;
      @(negedge clk);
      exp_v = (c == 2);
      n_cmp++; if (bus.flit_valid !== exp_v) begin n_bad++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, bus.flit_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (got_vec() !== flit_vec(5, 0, 0, 1))
          begin n_bad++; $display("FAIL single_flit got=%h exp=%h", got_vec(), flit_vec(5, 0, 0, 1)); end
      end
      n_cmp++; if (bus.err_zero_len !== (c >= 2)) begin n_bad++; $display("FAIL zero_err c=%0d got=%b exp=%b", c, bus.err_zero_len, (c >= 2)); end
      if (c >= 3) begin
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL zero_done c=%0d got=%b exp=1", c, bus.done); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    int   k;
    do_reset();
    offer(7, 2, 2);
    start_cycle();
    offer(9, 3, 2);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) start_cycle();
      if (c > 1) bus.fill_valid = 1'b0;
      @(negedge clk);
      exp_v = (c >= 2) && (c <= 5);
      n_cmp++; if (bus.flit_valid !== exp_v) begin n_bad++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, bus.flit_valid, exp_v); end
      if (exp_v) begin
        k = c - 2;
        n_cmp++; if (got_vec() !== flit_vec((k/2 != 0) ? 9 : 7, (k/2 != 0) ? 3 : 2, k%2, 2))
          begin n_bad++; $display("FAIL b2b_flit c=%0d got=%h", c, got_vec()); end
      end
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got=%b exp=1", bus.done); end
  endtask

  task automatic test_stall();
    logic stalled;
    int   k;
    do_reset();
    offer(4, 2, 4);
    start_cycle();
    offer(1, 0, 1);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) start_cycle();
      if (c > 1) bus.fill_valid = 1'b0;
      stalled = (c >= 4) && (c <= 8);
      bus.can_inject = stalled ? 4'b1011 : 4'b1111;
      @(negedge clk);
      if (stalled) begin
        n_cmp++; if (bus.flit_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid c=%0d got=%b exp=0", c, bus.flit_valid); end
        n_cmp++; if (got_vec() !== flit_vec(4, 2, 2, 4))
          begin n_bad++; $display("FAIL stall_frozen c=%0d got=%h exp=%h", c, got_vec(), flit_vec(4, 2, 2, 4)); end
      end else if (c >= 2 && c <= 11) begin
        k = (c < 4) ? c - 2 : c - 7;
        n_cmp++; if (bus.flit_valid !== 1'b1) begin n_bad++; $display("FAIL stall_resume_valid c=%0d got=%b exp=1", c, bus.flit_valid); end
        n_cmp++; if (got_vec() !== ((k < 4) ? flit_vec(4, 2, k, 4) : flit_vec(1, 0, 0, 1)))
          begin n_bad++; $display("FAIL stall_order c=%0d got=%h", c, got_vec()); end
      end else if (c == 12) begin
        n_cmp++; if ({bus.flit_valid, bus.done} !== 2'b01) begin n_bad++; $display("FAIL stall_end got=%b exp=01", {bus.flit_valid, bus.done}); end
      end
    end
  endtask

  task automatic test_full_reset();
    int taken = 0;
    do_reset();
    bus.flit_accept = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) start_cycle();
      offer(c + 1, 1, 3);
      @(negedge clk);
      if (bus.fill_ready) taken++;
    end
    n_cmp++; if (taken !== 9) begin n_bad++; $display("FAIL full_taken got=%0d exp=9", taken); end
    n_cmp++; if (bus.fill_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", bus.fill_ready); end
    start_cycle();
    bus.fill_valid  = 1'b0;
    bus.flit_accept = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.flit_valid, got_vec()} !== {1'b1, flit_vec(1, 1, 0, 3)})
      begin n_bad++; $display("FAIL full_head got=%h", {bus.flit_valid, got_vec()}); end
    start_cycle();
    bus.flit_accept = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.flit_valid, got_vec()} !== {1'b1, flit_vec(1, 1, 1, 3)})
      begin n_bad++; $display("FAIL full_body got=%h", {bus.flit_valid, got_vec()}); end
    start_cycle();
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.flit_valid, got_vec()} !== 19'h0)
      begin n_bad++; $display("FAIL midrst_flit got=%h exp=0", {bus.flit_valid, got_vec()}); end
    n_cmp++; if ({bus.done, bus.fill_ready, bus.err_zero_len} !== 3'b110)
      begin n_bad++; $display("FAIL midrst_status got=%b exp=110", {bus.done, bus.fill_ready, bus.err_zero_len}); end
    start_cycle();
    rst = 1'b0;
    set_idle();
  endtask

  task automatic test_timestamp();
    logic        seen = 1'b0;
    logic [15:0] stamp = '0;
    logic [15:0] exp_t;
    do_reset();
    offer(6, 3, 3);
    bus.flit_accept = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      start_cycle();
      bus.fill_valid  = 1'b0;
      bus.flit_accept = (c >= 5);
      @(negedge clk);
      if (bus.flit_valid && !seen) begin
        seen  = 1'b1;
        stamp = cyc;
      end
`ifdef FLIT_INJ_TIMESTAMP_EN
      exp_t = stamp;
`else
      exp_t = 16'h0;
`endif
      if (bus.flit_valid) begin
        n_cmp++; if (bus.flit_time !== exp_t) begin n_bad++; $display("FAIL ts_time c=%0d got=%0d exp=%0d", c, bus.flit_time, exp_t); end
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL ts_no_head got=%b exp=1", seen); end
  endtask

  task automatic test_random();
    logic [17:0] exp_q[$];
    logic [17:0] head_exp;
    int          sent = 0;
    int          n;
    int          budget = 0;
    logic        zero_seen = 1'b0;
    do_reset();
    while (!(sent == 40 && exp_q.size() == 0) && budget < 4000) begin
      start_cycle();
      budget++;
      if (sent < 40) begin
        n = $urandom_range(0, 4);
        bus.fill_valid    = ($urandom_range(0, 2) != 0);
        bus.fill_dst      = DST_W'($urandom_range(0, 63));
        bus.fill_vc       = VC_W'($urandom_range(0, 3));
        bus.fill_num_flit = NFLIT_W'(n);
        bus.can_inject    = MAXVC'($urandom_range(0, 15));
        bus.flit_accept   = ($urandom_range(0, 3) != 0);
      end else begin
        set_idle();
      end
      @(negedge clk);
      if (bus.flit_valid) begin
        n_cmp++; if (bus.can_inject[bus.flit_vc] !== 1'b1)
          begin n_bad++; $display("FAIL rnd_gate vc=%0d got=%b exp=1", bus.flit_vc, bus.can_inject[bus.flit_vc]); end
        head_exp = (exp_q.size() != 0) ? exp_q[0] : 18'h3ffff;
        n_cmp++; if (got_vec() !== head_exp) begin n_bad++; $display("FAIL rnd_flit got=%h exp=%h", got_vec(), head_exp); end
        if (bus.flit_accept && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (bus.fill_valid && bus.fill_ready) begin
        sent++;
        if (bus.fill_num_flit == '0) zero_seen = 1'b1;
        for (int i = 0; i < int'(bus.fill_num_flit); i++)
          exp_q.push_back(flit_vec(int'(bus.fill_dst), int'(bus.fill_vc), i, int'(bus.fill_num_flit)));
      end
    end
    n_cmp++; if (budget >= 4000) begin n_bad++; $display("FAIL rnd_timeout got=%0d left exp=0", exp_q.size()); end
    start_cycle();
    @(negedge clk);
    n_cmp++; if ({bus.flit_valid, bus.done, bus.err_zero_len} !== {1'b0, 1'b1, zero_seen})
      begin n_bad++; $display("FAIL rnd_end got=%b exp=%b", {bus.flit_valid, bus.done, bus.err_zero_len}, {1'b0, 1'b1, zero_seen}); end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_basic();
    test_single_zero();
    test_back_to_back();
    test_stall();
    test_full_reset();
    test_timestamp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
